// File: rtl/split_gen_pkg.sv
// Shared definitions for the split constraint checker stimulus stage.
//   state_e      : generator FSM states
//   LFSR_MASK    : Galois feedback mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED : LFSR value after reset and replacement for a zero seed
//   VAR_W/VAR_LSB: field widths and bit offsets of var_0..var_19 within a
//                  512-bit candidate (var_0 in the LSBs)
//   lfsr_next    : one right-shifting Galois step
//   var_slice    : extracts var_N from a candidate, zero-extended to 32 bits
package split_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_CHECK = 2'd2,
      ST_EMIT  = 2'd3
   } state_e;

   localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

   localparam int unsigned NUM_VARS = 32'd20;

   localparam int unsigned VAR_W [NUM_VARS] = '{
      32'd28, 32'd24, 32'd27, 32'd26, 32'd17, 32'd20, 32'd30, 32'd25, 32'd26, 32'd30,
      32'd30, 32'd32, 32'd32, 32'd21, 32'd19, 32'd19, 32'd32, 32'd24, 32'd26, 32'd24
   };

   localparam int unsigned VAR_LSB [NUM_VARS] = '{
      32'd0,   32'd28,  32'd52,  32'd79,  32'd105, 32'd122, 32'd142, 32'd172, 32'd197, 32'd223,
      32'd253, 32'd283, 32'd315, 32'd347, 32'd368, 32'd387, 32'd406, 32'd438, 32'd462, 32'd488
   };

   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : 32'h0000_0000);
   endfunction

   function automatic logic [31:0] var_slice(input logic [511:0] c, input int unsigned idx);
      logic [511:0] sh;
      logic [31:0]  mask;
      sh   = c >> VAR_LSB[idx];
      mask = (VAR_W[idx] == 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << VAR_W[idx]) - 32'd1);
      return sh[31:0] & mask;
   endfunction

endpackage

// File: rtl/split_candidate_gen_if.sv
// Solution output port of the candidate generator.
//   sol_valid : solution available (producer)
//   sol_data  : accepted candidate (producer)
//   sol_ready : consumer accepts the solution
// master = generator side, slave = consumer side.
interface split_candidate_gen_if
   import split_gen_pkg::*;
#(
   parameter int unsigned TOTAL_W = 32'd512
);
   logic               sol_valid;
   logic               sol_ready;
   logic [TOTAL_W-1:0] sol_data;

   modport master (output sol_valid, output sol_data, input sol_ready);
   modport slave  (input sol_valid, input sol_data, output sol_ready);
endinterface

// File: rtl/split_lfsr32.sv
// 32-bit Galois LFSR with zero-seed guard.
//   clk, rst_n : clock, asynchronous active-low reset (q returns to INIT)
//   load, seed : load seed; a zero seed loads INIT instead (zero is a lock-up state)
//   step       : advance one Galois step (load wins over step)
//   q          : current LFSR value
module split_lfsr32
   import split_gen_pkg::*;
#(
   parameter logic [31:0] INIT = split_gen_pkg::DEFAULT_SEED
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] q
);

   logic [31:0] lfsr_r;

   // LFSR state: load, step or hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= INIT;
      end else if (load) begin
         lfsr_r <= (seed == 32'h0000_0000) ? INIT : seed;
      end else if (step) begin
         lfsr_r <= lfsr_next(lfsr_r);
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign q = lfsr_r;

endmodule

// File: rtl/split_candidate_gen.sv
// Stimulus stage for a split constraint checker: shifts LFSR words into a
// candidate, lets the checker settle, samples its verdict and either emits
// the candidate on the solution port or regenerates it, up to MAX_TRIES.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, abort    : begin a solve (IDLE only) / return to IDLE from anywhere
//   seed_load, seed : reseed the LFSR (IDLE only, beats start)
//   cand, chk_x     : candidate to the checker / checker verdict
//   sol_if          : solution valid/ready/data port (master)
//   busy, fail      : not idle / one-cycle pulse when tries are exhausted
//   tries           : candidates checked in the current solve
//   reject_cnt      : rejected-candidate count, only when SPLIT_GEN_STATS_EN is defined
module split_candidate_gen
   import split_gen_pkg::*;
#(
   parameter int unsigned TOTAL_W      = 32'd512,
   parameter int unsigned CHECK_LAT    = 32'd1,
   parameter int unsigned MAX_TRIES    = 32'd64,
   parameter logic [31:0] DEFAULT_SEED = split_gen_pkg::DEFAULT_SEED,
   parameter bit          CONTINUOUS   = 1'b0
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  seed_load,
   input  logic [31:0]           seed,
   output logic [TOTAL_W-1:0]    cand,
   input  logic                  chk_x,
   split_candidate_gen_if.master sol_if,
   output logic                  busy,
   output logic                  fail,
   output logic [15:0]           tries
`ifdef SPLIT_GEN_STATS_EN
   ,
   output logic [31:0]           reject_cnt
`endif
);

   localparam int unsigned WORDS = TOTAL_W / 32'd32;

   state_e              state_r, state_s;
   logic [15:0]         word_cnt_r;
   logic [3:0]          lat_cnt_r;
   logic [TOTAL_W-1:0]  cand_r;
   logic [TOTAL_W-1:0]  sol_data_r;
   logic                sol_valid_r;
   logic                fail_r;
   logic [15:0]         tries_r;
   logic [31:0]         lfsr_q_s;
   logic [16:0]         next_try_s;
   logic                last_word_s, last_lat_s;
   logic                lfsr_load_s, lfsr_step_s, shift_s, sample_s;
   logic                pass_s, fail_s, handshake_s, clr_tries_s;

   split_lfsr32 #(.INIT(DEFAULT_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load_s),
      .seed  (seed),
      .step  (lfsr_step_s),
      .q     (lfsr_q_s)
   );

   assign last_word_s = (word_cnt_r == 16'(WORDS - 32'd1));
   assign last_lat_s  = (lat_cnt_r == 4'(CHECK_LAT - 32'd1));
   // Count including the sample about to be taken, so the retry decision
   // sees the attempt that just finished.
   assign next_try_s  = {1'b0, tries_r} + 17'd1;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and datapath strobes; abort overrides every other request
   always_comb begin
      state_s     = state_r;
      lfsr_load_s = 1'b0;
      lfsr_step_s = 1'b0;
      shift_s     = 1'b0;
      sample_s    = 1'b0;
      pass_s      = 1'b0;
      fail_s      = 1'b0;
      handshake_s = 1'b0;
      clr_tries_s = 1'b0;
      if (abort) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (seed_load) begin
                  lfsr_load_s = 1'b1;
               end else if (start) begin
                  clr_tries_s = 1'b1;
                  state_s     = ST_FILL;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_FILL: begin
               shift_s     = 1'b1;
               lfsr_step_s = 1'b1;
               if (last_word_s) begin
                  state_s = ST_CHECK;
               end else begin
                  state_s = ST_FILL;
               end
            end
            ST_CHECK: begin
               if (last_lat_s) begin
                  sample_s = 1'b1;
                  if (chk_x) begin
                     pass_s  = 1'b1;
                     state_s = ST_EMIT;
                  end else if (next_try_s < 17'(MAX_TRIES)) begin
                     state_s = ST_FILL;
                  end else begin
                     fail_s  = 1'b1;
                     state_s = ST_IDLE;
                  end
               end else begin
                  state_s = ST_CHECK;
               end
            end
            ST_EMIT: begin
               if (sol_valid_r && sol_if.sol_ready) begin
                  handshake_s = 1'b1;
                  if (CONTINUOUS) begin
                     clr_tries_s = 1'b1;
                     state_s     = ST_FILL;
                  end else begin
                     state_s = ST_IDLE;
                  end
               end else begin
                  state_s = ST_EMIT;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Word and settle-latency counters; cleared on abort so a new solve starts clean
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_r <= 16'd0;
         lat_cnt_r  <= 4'd0;
      end else if (abort) begin
         word_cnt_r <= 16'd0;
         lat_cnt_r  <= 4'd0;
      end else begin
         if (shift_s) begin
            word_cnt_r <= last_word_s ? 16'd0 : word_cnt_r + 16'd1;
         end
         if (state_r == ST_CHECK) begin
            lat_cnt_r <= last_lat_s ? 4'd0 : lat_cnt_r + 4'd1;
         end
      end
   end

   // Candidate shift register, solution capture and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_r      <= '0;
         sol_data_r  <= '0;
         sol_valid_r <= 1'b0;
         fail_r      <= 1'b0;
         tries_r     <= 16'd0;
      end else begin
         if (shift_s) begin
            cand_r <= {cand_r[TOTAL_W-33:0], lfsr_q_s};
         end
         if (pass_s) begin
            sol_data_r <= cand_r;
         end
         if (abort) begin
            sol_valid_r <= 1'b0;
         end else if (pass_s) begin
            sol_valid_r <= 1'b1;
         end else if (handshake_s) begin
            sol_valid_r <= 1'b0;
         end
         fail_r <= fail_s;
         if (clr_tries_s) begin
            tries_r <= 16'd0;
         end else if (sample_s) begin
            tries_r <= (tries_r == 16'hFFFF) ? tries_r : tries_r + 16'd1;
         end
      end
   end

`ifdef SPLIT_GEN_STATS_EN
   logic [31:0] reject_cnt_r;

   // Lifetime count of rejected candidates, saturating, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reject_cnt_r <= 32'd0;
      end else if (sample_s && !chk_x && (reject_cnt_r != 32'hFFFF_FFFF)) begin
         reject_cnt_r <= reject_cnt_r + 32'd1;
      end
   end

   assign reject_cnt = reject_cnt_r;
`endif

   assign cand             = cand_r;
   assign sol_if.sol_valid = sol_valid_r;
   assign sol_if.sol_data  = sol_data_r;
   assign busy             = (state_r != ST_IDLE);
   assign fail             = fail_r;
   assign tries            = tries_r;

endmodule

// File: tb/tb_split_candidate_gen.sv
// Bench for split_candidate_gen: three instances (defaults, MAX_TRIES=4,
// CONTINUOUS=1) driven by directed sequences. Expected solutions are pushed
// into per-instance queues when a solve is issued; negedge monitors pop and
// compare on every solution handshake.
module tb_split_candidate_gen;
   import split_gen_pkg::*;

   localparam logic [31:0] DSEED = 32'hACE1_2468;

   typedef struct packed {
      logic [511:0] data;
      logic [15:0]  tries;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks;
   int errors;
   exp_t q_a[$];
   exp_t q_c[$];

   logic         start_a, abort_a, seed_load_a, chk_a;
   logic [31:0]  seed_a;
   logic [511:0] cand_a;
   logic         busy_a, fail_a;
   logic [15:0]  tries_a;
   logic         start_b, abort_b, chk_b, busy_b, fail_b;
   logic [511:0] cand_b;
   logic [15:0]  tries_b;
   logic         start_c, abort_c, chk_c, busy_c, fail_c;
   logic [511:0] cand_c;
   logic [15:0]  tries_c;
`ifdef SPLIT_GEN_STATS_EN
   logic [31:0]  rc_a, rc_b, rc_c;
`endif

   split_candidate_gen_if #(.TOTAL_W(512)) if_a ();
   split_candidate_gen_if #(.TOTAL_W(512)) if_b ();
   split_candidate_gen_if #(.TOTAL_W(512)) if_c ();

   split_candidate_gen dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .seed_load(seed_load_a), .seed(seed_a), .cand(cand_a), .chk_x(chk_a),
      .sol_if(if_a), .busy(busy_a), .fail(fail_a), .tries(tries_a)
`ifdef SPLIT_GEN_STATS_EN
      , .reject_cnt(rc_a)
`endif
   );

   split_candidate_gen #(.MAX_TRIES(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .seed_load(1'b0), .seed(32'h0000_0000), .cand(cand_b), .chk_x(chk_b),
      .sol_if(if_b), .busy(busy_b), .fail(fail_b), .tries(tries_b)
`ifdef SPLIT_GEN_STATS_EN
      , .reject_cnt(rc_b)
`endif
   );

   split_candidate_gen #(.CONTINUOUS(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
      .seed_load(1'b0), .seed(32'h0000_0000), .cand(cand_c), .chk_x(chk_c),
      .sol_if(if_c), .busy(busy_c), .fail(fail_c), .tries(tries_c)
`ifdef SPLIT_GEN_STATS_EN
      , .reject_cnt(rc_c)
`endif
   );

   // Reference LFSR: x^32+x^22+x^2+x+1, right-shifting Galois form
   function automatic logic [31:0] lfsr_nx(input logic [31:0] v);
      logic [31:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   // Builds the 16-word candidate from st (first word ends in the MSBs) and advances st
   task automatic gen_cand(inout logic [31:0] st, output logic [511:0] c);
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c  = {c[479:0], st};
         st = lfsr_nx(st);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_wide(input string name, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Scoreboard monitors: compare every real handshake against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && if_a.sol_valid && if_a.sol_ready && !abort_a) begin
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL sol_a_unexpected: got data %h with nothing expected", if_a.sol_data);
         end else begin
            e = q_a.pop_front();
            if (if_a.sol_data !== e.data || tries_a !== e.tries) begin
               errors++;
               $display("FAIL sol_a: got %h tries %0d expected %h tries %0d",
                        if_a.sol_data, tries_a, e.data, e.tries);
            end
         end
      end
      if (rst_n && if_c.sol_valid && if_c.sol_ready && !abort_c) begin
         checks++;
         if (q_c.size() == 0) begin
            errors++;
            $display("FAIL sol_c_unexpected: got data %h with nothing expected", if_c.sol_data);
         end else begin
            e = q_c.pop_front();
            if (if_c.sol_data !== e.data || tries_c !== e.tries) begin
               errors++;
               $display("FAIL sol_c: got %h tries %0d expected %h tries %0d",
                        if_c.sol_data, tries_c, e.data, e.tries);
            end
         end
      end
   end

   task automatic seq_a();
      logic [31:0]  st;
      logic [511:0] c;
      int k;
      // reseed nonzero, then zero (must fall back to DSEED) together with start
      seed_load_a = 1'b1; seed_a = 32'h0000_0001; tick();
      seed_a = 32'h0000_0000; start_a = 1'b1; tick();
      seed_load_a = 1'b0; start_a = 1'b0;
      chk("seed_load_beats_start", busy_a, 1'b0);
      // always-true checker: latency, hold while stalled, handshake
      st = DSEED;
      gen_cand(st, c);
      q_a.push_back('{c, 16'd1});
      chk_a = 1'b1; start_a = 1'b1; tick(); start_a = 1'b0;
      chk("busy_after_start", busy_a, 1'b1);
      tick();
      chk("first_fill_word", cand_a[31:0], DSEED);
      k = 1;
      while (!if_a.sol_valid && k < 40) begin tick(); k++; end
      chk("latency_cycle", k + 1, 18);
      chk("tries_one", tries_a, 16'd1);
      repeat (5) begin
         tick();
         chk("hold_valid", if_a.sol_valid, 1'b1);
         chk_wide("hold_data", if_a.sol_data, c);
      end
      if_a.sol_ready = 1'b1; tick(); if_a.sol_ready = 1'b0;
      chk("valid_after_hs", if_a.sol_valid, 1'b0);
      chk("idle_after_hs", busy_a, 1'b0);
      // two rejects, accept on attempt 3
      gen_cand(st, c); gen_cand(st, c); gen_cand(st, c);
      q_a.push_back('{c, 16'd3});
      chk_a = 1'b0; if_a.sol_ready = 1'b1; start_a = 1'b1; tick(); start_a = 1'b0;
      k = 0;
      while (!if_a.sol_valid && k < 80) begin
         if (k == 39) chk_a = 1'b1;
         tick(); k++;
      end
      chk("retry_latency", k, 51);
      tick();
      chk("retry_idle", busy_a, 1'b0);
      chk("retry_fail", fail_a, 1'b0);
      // abort during FILL, with a simultaneous start
      if_a.sol_ready = 1'b0; start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (4) tick();
      abort_a = 1'b1; start_a = 1'b1; tick(); abort_a = 1'b0; start_a = 1'b0;
      chk("abort_fill_busy", busy_a, 1'b0);
      chk("abort_fill_valid", if_a.sol_valid, 1'b0);
      chk("abort_fill_fail", fail_a, 1'b0);
      tick();
      chk("abort_start_ignored", busy_a, 1'b0);
      repeat (4) st = lfsr_nx(st);
      // abort during EMIT, with a simultaneous handshake; lfsr kept from the aborted fill
      gen_cand(st, c);
      start_a = 1'b1; tick(); start_a = 1'b0;
      k = 0;
      while (!if_a.sol_valid && k < 40) begin tick(); k++; end
      chk("emit_latency", k, 17);
      chk_wide("data_after_fill_abort", if_a.sol_data, c);
      abort_a = 1'b1; if_a.sol_ready = 1'b1; tick(); abort_a = 1'b0; if_a.sol_ready = 1'b0;
      chk("abort_emit_valid", if_a.sol_valid, 1'b0);
      chk("abort_emit_busy", busy_a, 1'b0);
      chk("abort_emit_fail", fail_a, 1'b0);
   endtask

   task automatic seq_b();
      int first = -1;
      int npulse = 0;
      logic busy_first = 1'b1;
      logic saw_valid = 1'b0;
      start_b = 1'b1; tick(); start_b = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         tick();
         if (fail_b) begin
            npulse++;
            if (first < 0) begin
               first = k;
               busy_first = busy_b;
            end
         end
         if (if_b.sol_valid) saw_valid = 1'b1;
      end
      chk("fail_cycle", first + 1, 69);
      chk("fail_once", npulse, 1);
      chk("busy_at_fail", busy_first, 1'b0);
      chk("no_valid_on_fail", saw_valid, 1'b0);
      chk("tries_at_fail", tries_b, 16'd4);
`ifdef SPLIT_GEN_STATS_EN
      chk("reject_cnt", rc_b, 32'd4);
`endif
   endtask

   task automatic seq_c();
      logic [31:0]  st;
      logic [511:0] c;
      int idx[$];
      st = DSEED;
      for (int n = 0; n < 5; n++) begin
         gen_cand(st, c);
         q_c.push_back('{c, 16'd1});
      end
      if_c.sol_ready = 1'b1; start_c = 1'b1; tick(); start_c = 1'b0;
      for (int k = 1; k <= 95; k++) begin
         tick();
         if (if_c.sol_valid) idx.push_back(k);
      end
      abort_c = 1'b1; tick(); abort_c = 1'b0;
      chk("cont_pulse_count", idx.size(), 5);
      foreach (idx[i]) chk("cont_pulse_cycle", idx[i], 17 + 18 * i);
      chk("cont_abort_idle", busy_c, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; seed_load_a = 1'b0; seed_a = 32'h0000_0000; chk_a = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; chk_b = 1'b0;
      start_c = 1'b0; abort_c = 1'b0; chk_c = 1'b1;
      if_a.sol_ready = 1'b0; if_b.sol_ready = 1'b0; if_c.sol_ready = 1'b0;
      repeat (3) tick();
      chk("reset_cand", {63'd0, |cand_a}, 64'd0);
      chk("reset_sol_data", {63'd0, |if_a.sol_data}, 64'd0);
      chk("reset_sol_valid", if_a.sol_valid, 1'b0);
      chk("reset_busy", busy_a, 1'b0);
      chk("reset_fail", fail_a, 1'b0);
      chk("reset_tries", tries_a, 16'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset", busy_a, 1'b0);
      fork
         seq_a();
         seq_b();
         seq_c();
      join
      tick();
      chk("queue_a_drained", q_a.size(), 0);
      chk("queue_c_drained", q_c.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
